button_event_gen: RTL and testbench

BUTTON_EVENT_GEN -- requirements
Module: button_event_gen

---
 rtl/blackjack_pkg.sv | 31 +++
 rtl/button_event_gen.sv | 126 ++++++++++++
 tb/tb_button_event_gen.sv | 138 +++++++++++++
 3 files changed

// File: rtl/blackjack_pkg.sv
// Shared types for the blackjack UI: FSM states and button codes.
// Also holds the fixed-priority request encoder used by the button event generator.
package blackjack_pkg;

    typedef enum logic [1:0] {
        StIdle        = 2'd0,
        StArming      = 2'd1,
        StFire        = 2'd2,
        StWaitRelease = 2'd3
    } btn_state_e;

    typedef enum logic [1:0] {
        BtnNone  = 2'd0,
        BtnDeal  = 2'd1,
        BtnHit   = 2'd2,
        BtnStand = 2'd3
    } button_e;

    // Fixed priority: deal > hit > stand.
    function automatic button_e req_encode(input logic deal, input logic hit, input logic stand);
        if (deal) begin
            return BtnDeal;
        end else if (hit) begin
            return BtnHit;
        end else if (stand) begin
            return BtnStand;
        end
        return BtnNone;
    endfunction

endpackage

// File: rtl/button_event_gen.sv
// Turns held button-click levels into single-cycle events: a press must be held for
// HOLD_CYCLES, and all buttons must be released for RELEASE_CYCLES before re-arming.
module button_event_gen
    import blackjack_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES    = 65000,
    parameter int unsigned RELEASE_CYCLES = 65000
) (
    input  logic clk,
    input  logic rst,
    input  logic deal,
    input  logic hit,
    input  logic stand,
    output logic deal_pulse,
    output logic hit_pulse,
    output logic stand_pulse,
    output logic busy
);

    localparam int unsigned MaxCycles = (HOLD_CYCLES > RELEASE_CYCLES) ? HOLD_CYCLES
                                                                        : RELEASE_CYCLES;
    localparam int unsigned CntW      = $clog2(MaxCycles + 1);

    localparam logic [CntW-1:0] HoldLast = CntW'(HOLD_CYCLES - 1);
    localparam logic [CntW-1:0] RelLast  = CntW'(RELEASE_CYCLES - 1);

    btn_state_e      r_state;
    btn_state_e      w_state_next;
    button_e         r_cand;
    button_e         w_cand_next;
    logic [CntW-1:0] r_hold_cnt;
    logic [CntW-1:0] w_hold_next;
    logic [CntW-1:0] r_rel_cnt;
    logic [CntW-1:0] w_rel_next;
    logic            r_deal_pulse;
    logic            r_hit_pulse;
    logic            r_stand_pulse;
    logic            r_busy;

    button_e         w_req;
    logic [CntW-1:0] w_hold_inc;
    logic [CntW-1:0] w_rel_inc;
    logic            w_fire_next;

    assign w_req = req_encode(deal, hit, stand);

    // Saturating increments: counters hold at all-ones instead of wrapping.
    assign w_hold_inc = (r_hold_cnt == '1) ? r_hold_cnt : r_hold_cnt + CntW'(1);
    assign w_rel_inc  = (r_rel_cnt == '1) ? r_rel_cnt : r_rel_cnt + CntW'(1);

    always_comb begin
        w_state_next = r_state;
        w_cand_next  = r_cand;
        w_hold_next  = r_hold_cnt;
        w_rel_next   = r_rel_cnt;

        unique case (r_state)
            StIdle: begin
                if (w_req != BtnNone) begin
                    w_cand_next  = w_req;
                    w_hold_next  = '0;
                    w_state_next = StArming;
                end
            end
            StArming: begin
                if (w_req == BtnNone) begin
                    w_state_next = StIdle;
                end else if (w_req != r_cand) begin
                    w_cand_next = w_req;
                    w_hold_next = '0;
                end else if (r_hold_cnt == HoldLast) begin
                    w_state_next = StFire;
                end else begin
                    w_hold_next = w_hold_inc;
                end
            end
            StFire: begin
                w_rel_next   = '0;
                w_state_next = StWaitRelease;
            end
            StWaitRelease: begin
                if (w_req != BtnNone) begin
                    w_rel_next = '0;
                end else if (r_rel_cnt == RelLast) begin
                    w_state_next = StIdle;
                end else begin
                    w_rel_next = w_rel_inc;
                end
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    // Pulses are registered off the next state so they line up with the FIRE cycle.
    assign w_fire_next = (w_state_next == StFire);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= StIdle;
            r_cand        <= BtnNone;
            r_hold_cnt    <= '0;
            r_rel_cnt     <= '0;
            r_deal_pulse  <= 1'b0;
            r_hit_pulse   <= 1'b0;
            r_stand_pulse <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_cand        <= w_cand_next;
            r_hold_cnt    <= w_hold_next;
            r_rel_cnt     <= w_rel_next;
            r_deal_pulse  <= w_fire_next && (w_cand_next == BtnDeal);
            r_hit_pulse   <= w_fire_next && (w_cand_next == BtnHit);
            r_stand_pulse <= w_fire_next && (w_cand_next == BtnStand);
            r_busy        <= (w_state_next != StIdle);
        end
    end

    assign deal_pulse  = r_deal_pulse;
    assign hit_pulse   = r_hit_pulse;
    assign stand_pulse = r_stand_pulse;
    assign busy        = r_busy;

endmodule

// File: tb/tb_button_event_gen.sv
// Directed bench for button_event_gen with HOLD_CYCLES=4, RELEASE_CYCLES=3.
// Each step drives one cycle of inputs and compares {deal,hit,stand pulse, busy} after the edge.
module tb_button_event_gen;

    logic clk;
    logic rst;
    logic deal;
    logic hit;
    logic stand;
    logic deal_pulse;
    logic hit_pulse;
    logic stand_pulse;
    logic busy;

    int unsigned n_checks;
    int unsigned n_bad;

    button_event_gen #(
        .HOLD_CYCLES   (4),
        .RELEASE_CYCLES(3)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .deal       (deal),
        .hit        (hit),
        .stand      (stand),
        .deal_pulse (deal_pulse),
        .hit_pulse  (hit_pulse),
        .stand_pulse(stand_pulse),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got {d,h,s,busy}=%b want %b at t=%0t", tag, obs, exp, $time);
        end
    endtask

    // One clock: drive inputs, wait for the edge, sample 1 time unit later.
    task automatic step(input string tag, input logic d, input logic h, input logic s,
                        input logic r, input logic [3:0] exp);
        deal  = d;
        hit   = h;
        stand = s;
        rst   = r;
        @(posedge clk);
        #1;
        check(tag, {deal_pulse, hit_pulse, stand_pulse, busy}, exp);
    endtask

    // Three idle cycles from WAIT_RELEASE: busy drops after the third.
    task automatic release3(input string tag);
        step({tag, "_rel1"}, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0001);
        step({tag, "_rel2"}, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0001);
        step({tag, "_rel3"}, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000);
    endtask

    initial begin
        n_checks = 0;
        n_bad    = 0;
        deal     = 1'b0;
        hit      = 1'b0;
        stand    = 1'b0;
        rst      = 1'b1;

        step("reset0", 1'b0, 1'b0, 1'b0, 1'b1, 4'b0000);
        step("reset_held_hit", 1'b0, 1'b1, 1'b0, 1'b1, 4'b0000);
        step("idle_quiet", 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000);

        // Hit held 20 cycles: single hit pulse on cycle 5.
        for (int n = 1; n <= 20; n++) begin
            step($sformatf("hit_hold_%0d", n), 1'b0, 1'b1, 1'b0, 1'b0,
                 {1'b0, (n == 5), 1'b0, 1'b1});
        end
        release3("hit_hold");

        // Stand for 3 cycles, then release: no pulse, back to idle.
        for (int n = 1; n <= 3; n++) begin
            step($sformatf("stand_short_%0d", n), 1'b0, 1'b0, 1'b1, 1'b0, 4'b0001);
        end
        step("stand_short_drop", 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000);
        step("stand_short_idle", 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000);

        // Deal and hit together: deal wins.
        for (int n = 1; n <= 10; n++) begin
            step($sformatf("deal_hit_%0d", n), 1'b1, 1'b1, 1'b0, 1'b0,
                 {(n == 5), 1'b0, 1'b0, 1'b1});
        end
        release3("deal_hit");

        // Deal for 2 cycles then hit: count restarts on the switch.
        for (int n = 1; n <= 2; n++) begin
            step($sformatf("switch_deal_%0d", n), 1'b1, 1'b0, 1'b0, 1'b0, 4'b0001);
        end
        for (int n = 1; n <= 10; n++) begin
            step($sformatf("switch_hit_%0d", n), 1'b0, 1'b1, 1'b0, 1'b0,
                 {1'b0, (n == 5), 1'b0, 1'b1});
        end
        release3("switch");

        // Release glitch: low 2, high 1, low 3 before re-arming.
        for (int n = 1; n <= 6; n++) begin
            step($sformatf("glitch_stand_%0d", n), 1'b0, 1'b0, 1'b1, 1'b0,
                 {1'b0, 1'b0, (n == 5), 1'b1});
        end
        step("glitch_low1", 1'b0, 1'b0, 1'b0, 1'b0, 4'b0001);
        step("glitch_low2", 1'b0, 1'b0, 1'b0, 1'b0, 4'b0001);
        step("glitch_high", 1'b0, 1'b0, 1'b1, 1'b0, 4'b0001);
        step("glitch_low3", 1'b0, 1'b0, 1'b0, 1'b0, 4'b0001);
        step("glitch_low4", 1'b0, 1'b0, 1'b0, 1'b0, 4'b0001);
        step("glitch_low5", 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000);
        for (int n = 1; n <= 6; n++) begin
            step($sformatf("glitch_new_%0d", n), 1'b1, 1'b0, 1'b0, 1'b0,
                 {(n == 5), 1'b0, 1'b0, 1'b1});
        end
        release3("glitch_new");

        // Reset on the edge that would enter FIRE: no pulse, then a fresh press.
        for (int n = 1; n <= 4; n++) begin
            step($sformatf("rst_fire_arm_%0d", n), 1'b0, 1'b1, 1'b0, 1'b0, 4'b0001);
        end
        step("rst_fire_reset", 1'b0, 1'b1, 1'b0, 1'b1, 4'b0000);
        for (int n = 1; n <= 6; n++) begin
            step($sformatf("rst_fire_again_%0d", n), 1'b0, 1'b1, 1'b0, 1'b0,
                 {1'b0, (n == 5), 1'b0, 1'b1});
        end
        release3("rst_fire");

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
